// File: rtl/joy_serial_reader.sv
// Serial (74HC165-style) joystick chain reader: loads the pads, shifts PLAYERS*BITS
// bits in, and commits per-player button words and presence flags once per frame.
module joy_serial_reader #(
    parameter int PLAYERS = 2,
    parameter int BITS    = 12,
    parameter int DIV     = 32,
    parameter int GAP     = 1024
) (
    input  logic                    clk,
    input  logic                    sys_reset,
    input  logic                    enable,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*16-1:0]   joystick,
    output logic [PLAYERS-1:0]      present,
    output logic                    frame_done
);
    // state    | meaning
    // IDLE     | outputs idle, waiting for enable
    // LOAD     | joy_load low for DIV cycles
    // SHIFT_LO | joy_clk low for DIV cycles, sample bit k on the last cycle
    // SHIFT_HI | joy_clk high for DIV cycles, advance k or finish
    // COMMIT   | one cycle: update joystick/present, pulse frame_done
    // GAP      | GAP idle cycles before the next frame
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHLO   = 3'd2;
    localparam logic [2:0] S_SHHI   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    localparam int N    = PLAYERS * BITS;
    localparam int TMAX = (DIV > GAP) ? DIV : GAP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int KW   = (N > 1) ? $clog2(N) : 1;

    if (PLAYERS < 1 || PLAYERS > 4) begin : g_bad_players
        $error("joy_serial_reader: PLAYERS must be in 1..4");
    end
    if (BITS < 1 || BITS > 16) begin : g_bad_bits
        $error("joy_serial_reader: BITS must be in 1..16");
    end
    if (DIV < 4) begin : g_bad_div
        $error("joy_serial_reader: DIV must be >= 4");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("joy_serial_reader: GAP must be >= 1");
    end

    logic [2:0]              state_q, state_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    tmr_done;
    logic [1:0]              sync_q;
    logic [N-1:0]            shadow_q;
    logic                    joy_clk_q, joy_load_q, frame_done_q;
    logic [PLAYERS*16-1:0]   joystick_q, joy_nxt;
    logic [PLAYERS-1:0]      present_q, pres_nxt;
    logic [BITS-1:0]         pbits;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        k_d      = k_q;
        tmr_done = (tmr_q == '0);
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_LOAD;
                    tmr_d   = TW'(DIV - 1);
                end
            end
            S_LOAD: begin
                if (tmr_done) begin
                    state_d = S_SHLO;
                    tmr_d   = TW'(DIV - 1);
                    k_d     = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_SHLO: begin
                if (tmr_done) begin
                    state_d = S_SHHI;
                    tmr_d   = TW'(DIV - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_SHHI: begin
                if (!tmr_done) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (k_q == KW'(N - 1)) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_SHLO;
                    tmr_d   = TW'(DIV - 1);
                    k_d     = k_q + 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = S_GAP;
                tmr_d   = TW'(GAP - 1);
            end
            S_GAP: begin
                if (!tmr_done) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (enable) begin
                    state_d = S_LOAD;
                    tmr_d   = TW'(DIV - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A player whose every bit reads pressed is treated as absent (line held low).
    always_comb begin
        joy_nxt  = '0;
        pres_nxt = '0;
        pbits    = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            pbits       = shadow_q[p*BITS +: BITS];
            pres_nxt[p] = ~&pbits;
            joy_nxt[p*16 +: 16] = pres_nxt[p] ? 16'(pbits) : 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_reset) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            k_q          <= '0;
            sync_q       <= '0;
            shadow_q     <= '0;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            frame_done_q <= 1'b0;
            joystick_q   <= '0;
            present_q    <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            k_q          <= k_d;
            sync_q       <= {sync_q[0], joy_data};
            if (state_q == S_SHLO && tmr_done) begin
                shadow_q[k_q] <= ~sync_q[1];
            end
            joy_clk_q    <= (state_d == S_SHHI);
            joy_load_q   <= (state_d != S_LOAD);
            frame_done_q <= (state_d == S_COMMIT);
            if (state_d == S_COMMIT) begin
                joystick_q <= joy_nxt;
                present_q  <= pres_nxt;
            end
        end
    end

    assign joy_clk    = joy_clk_q;
    assign joy_load   = joy_load_q;
    assign frame_done = frame_done_q;
    assign joystick   = joystick_q;
    assign present    = present_q;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench for joy_serial_reader: a 2-player instance for timing/feature tests and a
// 4-player instance driven by a randomised pad chain, both checked via scoreboards.
module tb_joy_serial_reader;
    localparam int NA = 24;
    localparam int N4 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_a, en_a, jd_a, jclk_a, jload_a, fd_a;
    logic [31:0] joy_a;
    logic [1:0]  pres_a;
    logic        rst_4, en_4, jd_4, jclk_4, jload_4, fd_4;
    logic [63:0] joy_4;
    logic [3:0]  pres_4;

    logic [15:0] btn_a [2];
    logic [1:0]  conn_a;
    logic [15:0] btn_4 [4];
    logic [3:0]  conn_4;
    int          idx_a = 0;
    int          idx_4 = 0;
    logic        jc_prev_a = 1'b0;
    logic        jc_prev_4 = 1'b0;

    logic [33:0] sb_a [$];
    logic [67:0] sb_4 [$];

    joy_serial_reader #(.PLAYERS(2), .BITS(12), .DIV(4), .GAP(8)) dut (
        .clk(clk), .sys_reset(rst_a), .enable(en_a), .joy_data(jd_a),
        .joy_clk(jclk_a), .joy_load(jload_a), .joystick(joy_a),
        .present(pres_a), .frame_done(fd_a)
    );

    joy_serial_reader #(.PLAYERS(4), .BITS(16), .DIV(8), .GAP(1)) dut4 (
        .clk(clk), .sys_reset(rst_4), .enable(en_4), .joy_data(jd_4),
        .joy_clk(jclk_4), .joy_load(jload_4), .joystick(joy_4),
        .present(pres_4), .frame_done(fd_4)
    );

    // Pad chain: load resets the bit pointer, each joy_clk rise moves to the next bit.
    always @(negedge clk) begin
        if (!jload_a) idx_a = 0;
        else if (jclk_a && !jc_prev_a) idx_a = idx_a + 1;
        jc_prev_a = jclk_a;
        if (!jload_4) idx_4 = 0;
        else if (jclk_4 && !jc_prev_4) idx_4 = idx_4 + 1;
        jc_prev_4 = jclk_4;
    end

    always_comb begin
        jd_a = 1'b1;
        if (idx_a < NA) jd_a = conn_a[idx_a/12] ? ~btn_a[idx_a/12][idx_a%12] : 1'b0;
        jd_4 = 1'b1;
        if (idx_4 < N4) jd_4 = conn_4[idx_4/16] ? ~btn_4[idx_4/16][idx_4%16] : 1'b0;
    end

    function automatic logic [33:0] model_a();
        logic [31:0] j = '0;
        logic [1:0]  p = '0;
        for (int i = 0; i < 2; i++) begin
            if (conn_a[i] && btn_a[i][11:0] != 12'hFFF) begin
                p[i] = 1'b1;
                j[i*16 +: 12] = btn_a[i][11:0];
            end
        end
        return {p, j};
    endfunction

    function automatic logic [67:0] model_4();
        logic [63:0] j = '0;
        logic [3:0]  p = '0;
        for (int i = 0; i < 4; i++) begin
            if (conn_4[i] && btn_4[i] != 16'hFFFF) begin
                p[i] = 1'b1;
                j[i*16 +: 16] = btn_4[i];
            end
        end
        return {p, j};
    endfunction

    task automatic randomize_pad4();
        for (int i = 0; i < 4; i++) begin
            conn_4[i] = ($urandom_range(0, 5) != 0);
            btn_4[i]  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
        end
    endtask

    task automatic wait_frame(input bit four, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            ok = four ? fd_4 : fd_a;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0; en_a = 1'b1; conn_a = 2'b11; btn_a[0] = '0; btn_a[1] = '0;
        rst_4 = 1'b0; en_4 = 1'b0; conn_4 = '0;
        for (int i = 0; i < 4; i++) btn_4[i] = '0;
        repeat (3) @(negedge clk);
        checks++; if (joy_a !== 32'h0) begin errors++; $display("FAIL reset_joystick: got %h want 0", joy_a); end
        checks++; if (pres_a !== 2'b00) begin errors++; $display("FAIL reset_present: got %b want 00", pres_a); end
        checks++; if (jclk_a !== 1'b0) begin errors++; $display("FAIL reset_joy_clk: got %b want 0", jclk_a); end
        checks++; if (jload_a !== 1'b1) begin errors++; $display("FAIL reset_joy_load: got %b want 1", jload_a); end
        checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", fd_a); end
        checks++; if ({pres_4, joy_4} !== 68'h0) begin errors++; $display("FAIL reset_dut4: got %h want 0", {pres_4, joy_4}); end
    endtask

    task automatic test_frame_timing();
        logic el, ec, ef;
        logic [33:0] exp;
        sb_a.push_back(model_a());
        rst_a = 1'b1;
        for (int c = 1; c <= 206; c++) begin
            @(negedge clk);
            el = !((c >= 1 && c <= 4) || c == 206);
            ec = (c >= 5 && c <= 196) && (((c - 5) / 4) % 2 == 1);
            ef = (c == 197);
            checks++;
            if ({jload_a, jclk_a, fd_a} !== {el, ec, ef}) begin
                errors++;
                $display("FAIL frame_timing c=%0d: load/clk/done got %b%b%b want %b%b%b",
                         c, jload_a, jclk_a, fd_a, el, ec, ef);
            end
            if (c == 197) begin
                exp = sb_a.pop_front();
                checks++;
                if ({pres_a, joy_a} !== exp) begin
                    errors++; $display("FAIL idle_frame_word: got %h want %h", {pres_a, joy_a}, exp);
                end
            end
        end
    endtask

    task automatic test_pattern();
        int n; bit ok; logic [33:0] exp;
        btn_a[0] = 16'h00A5; btn_a[1] = 16'h0801;
        sb_a.push_back(model_a());
        wait_frame(1'b0, 400, n, ok);
        exp = sb_a.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL pattern_timeout: no frame_done in %0d cycles", n); end
        checks++; if ({pres_a, joy_a} !== exp) begin errors++; $display("FAIL pattern_word: got %h want %h", {pres_a, joy_a}, exp); end
        checks++; if (joy_a !== 32'h0801_00A5) begin errors++; $display("FAIL pattern_const: got %h want 080100a5", joy_a); end
        checks++; if (joy_a[15:12] !== 4'h0 || joy_a[31:28] !== 4'h0) begin
            errors++; $display("FAIL pattern_upper_bits: got %h %h want 0 0", joy_a[15:12], joy_a[31:28]);
        end
    endtask

    task automatic test_absent();
        int n; bit ok; logic [33:0] exp;
        conn_a = 2'b00;
        sb_a.push_back(model_a());
        wait_frame(1'b0, 400, n, ok);
        exp = sb_a.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL absent_timeout: no frame_done in %0d cycles", n); end
        checks++; if ({pres_a, joy_a} !== exp) begin errors++; $display("FAIL absent_word: got %h want %h", {pres_a, joy_a}, exp); end
        checks++; if (pres_a !== 2'b00) begin errors++; $display("FAIL absent_present: got %b want 00", pres_a); end
        conn_a = 2'b10; btn_a[1] = 16'h0008;
        sb_a.push_back(model_a());
        wait_frame(1'b0, 400, n, ok);
        exp = sb_a.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL p2only_timeout: no frame_done in %0d cycles", n); end
        checks++; if ({pres_a, joy_a} !== exp) begin errors++; $display("FAIL p2only_word: got %h want %h", {pres_a, joy_a}, exp); end
        checks++; if (pres_a !== 2'b10 || joy_a[19] !== 1'b1) begin
            errors++; $display("FAIL p2only_const: present %b bit19 %b want 10 1", pres_a, joy_a[19]);
        end
    endtask

    task automatic test_enable_drop();
        int n; bit ok; logic [33:0] exp;
        wait_frame(1'b0, 400, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_sync_timeout: no frame_done in %0d cycles", n); end
        repeat (58) @(negedge clk);
        en_a = 1'b0;
        sb_a.push_back(model_a());
        wait_frame(1'b0, 400, n, ok);
        exp = sb_a.pop_front();
        checks++; if (!ok || n != 147) begin errors++; $display("FAIL drop_commit_cycle: got %0d cycles (seen %0d) want 147", n, ok); end
        checks++; if ({pres_a, joy_a} !== exp) begin errors++; $display("FAIL drop_word: got %h want %h", {pres_a, joy_a}, exp); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (jload_a !== 1'b1 || jclk_a !== 1'b0 || fd_a !== 1'b0) begin
                errors++; $display("FAIL drop_idle i=%0d: load/clk/done got %b%b%b want 100", i, jload_a, jclk_a, fd_a);
            end
        end
        en_a = 1'b1;
        @(negedge clk);
        checks++; if (jload_a !== 1'b0) begin errors++; $display("FAIL reenable_load: got %b want 0", jload_a); end
    endtask

    task automatic test_reset_mid();
        int n; bit ok; logic [33:0] exp;
        n = 0;
        while (jclk_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (jclk_a !== 1'b1) begin errors++; $display("FAIL midreset_reach_shift: joy_clk got %b want 1", jclk_a); end
        checks++; if (joy_a !== 32'h0008_0000) begin errors++; $display("FAIL midreset_hold: got %h want 00080000", joy_a); end
        rst_a = 1'b0;
        @(negedge clk);
        checks++; if (joy_a !== 32'h0) begin errors++; $display("FAIL midreset_joystick: got %h want 0", joy_a); end
        checks++; if (pres_a !== 2'b00) begin errors++; $display("FAIL midreset_present: got %b want 00", pres_a); end
        checks++; if (jclk_a !== 1'b0 || jload_a !== 1'b1) begin
            errors++; $display("FAIL midreset_pins: clk/load got %b%b want 01", jclk_a, jload_a);
        end
        rst_a = 1'b1;
        sb_a.push_back(model_a());
        @(negedge clk);
        checks++; if (jload_a !== 1'b0) begin errors++; $display("FAIL restart_load: got %b want 0", jload_a); end
        wait_frame(1'b0, 400, n, ok);
        exp = sb_a.pop_front();
        checks++; if (!ok || n != 196) begin errors++; $display("FAIL restart_commit_cycle: got %0d (seen %0d) want 196", n, ok); end
        checks++; if ({pres_a, joy_a} !== exp) begin errors++; $display("FAIL restart_word: got %h want %h", {pres_a, joy_a}, exp); end
    endtask

    task automatic test_four_players();
        int n; bit ok; logic [67:0] exp;
        randomize_pad4();
        sb_4.push_back(model_4());
        rst_4 = 1'b1; en_4 = 1'b1;
        for (int f = 0; f < 20; f++) begin
            wait_frame(1'b1, 1200, n, ok);
            exp = sb_4.pop_front();
            checks++;
            if (!ok || n != ((f == 0) ? 1033 : 1034)) begin
                errors++; $display("FAIL p4_period f=%0d: got %0d (seen %0d) want %0d", f, n, ok, (f == 0) ? 1033 : 1034);
            end
            checks++;
            if ({pres_4, joy_4} !== exp) begin
                errors++; $display("FAIL p4_word f=%0d: got %h want %h", f, {pres_4, joy_4}, exp);
            end
            randomize_pad4();
            sb_4.push_back(model_4());
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_pattern();
        test_absent();
        test_enable_drop();
        test_reset_mid();
        test_four_players();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/joy_serial_reader.md
Name: joy_serial_reader

Overview:
- Parametrised serial (74HC165-style shift-register) joystick reader for the UserIO port.
- Successor to the fixed 2-player DB15 reader: player count, bits per player, shift clock rate and inter-frame gap are configurable.
- Adds per-player presence detection and a frame-done strobe.
- Sits between USER_IN/USER_OUT pin muxing and the joystick mux feeding the core's button inputs.

Parameters:
- PLAYERS, 2, number of pads chained on the serial line (1..4).
- BITS, 12, bits shifted per player (1..16).
- DIV, 32, clk cycles per half-period of joy_clk and length of the load pulse (>=4).
- GAP, 1024, idle clk cycles between frames (>=1).

Ports:
- clk  input  1  system clock, 40-50 MHz; all logic on rising edge.
- sys_reset  input  1  synchronous reset, active-low.
- enable  input  1  when high, frames repeat back-to-back (separated by GAP).
- joy_data  input  1  serial data from the pad chain, active-low (0 = pressed); asynchronous.
- joy_clk  output  1  shift clock to the pads.
- joy_load  output  1  parallel-load strobe, active-low.
- joystick  output  PLAYERS*16  player p occupies [16p+15:16p]; active-high; bits BITS..15 are always 0.
- present  output  PLAYERS  per-player "pad connected" flag.
- frame_done  output  1  one-cycle pulse when joystick/present update.

Behaviour:
- Reset (sys_reset=0 at a clk edge): state=IDLE, joy_clk=0, joy_load=1, joystick=0, present=0, frame_done=0.
  - Shadow register, counters and synchroniser are cleared.
  - Reset mid-frame aborts the frame immediately; no partial commit.
- joy_data passes through a 2-flop synchroniser before use (2-cycle latency; covered because DIV>=4).
- Let N = PLAYERS*BITS. Serial bit k (k=0 is first) maps to player k/BITS, bit k%BITS.
- States:
  - IDLE: outputs at idle levels. Go to LOAD when enable=1.
  - LOAD: joy_load=0 for DIV cycles, then SHIFT_LO with bit counter k=0.
  - SHIFT_LO: joy_clk=0 for DIV cycles. On the last cycle, shadow[k] <= ~sync_data. Then go to SHIFT_HI.
  - SHIFT_HI: joy_clk=1 for DIV cycles. Then k++ and go to SHIFT_LO, or go to COMMIT when k = N-1.
  - COMMIT: exactly one cycle.
    - present[p] = 0 if all BITS of player p were pressed (line stuck low or pad absent), else 1.
    - joystick[p] = shadow bits of player p when present[p]=1, else 0.
    - frame_done=1 on this cycle only. Then go to GAP.
  - GAP: GAP cycles with idle outputs. Then LOAD if enable=1, else IDLE.
- Frame period with enable held high: DIV + 2*DIV*N + 1 + GAP cycles. IDLE is not visited between frames.
- enable dropping mid-frame does not abort; the frame completes and commits. IDLE is entered after GAP.
- joystick and present hold their last committed value between commits. They are glitch-free (registered, single-cycle update).
- Output pins joy_clk and joy_load are registered (no combinational path).
- Counter widths are sized by $clog2 of DIV, N and GAP. Every count is a terminal-compare; there is no wrap-around past the terminal count.
- Illegal parameter values fail elaboration via generate-time $error.

Test Plan:
(Defaults PLAYERS=2, BITS=12, DIV=4, GAP=8 unless stated; frame = 4+192+1+8 = 205 cycles.)
1. Release reset with enable=1 and joy_data=1.
   - joy_load low for cycles 1-4; 24 joy_clk pulses of 4 low / 4 high.
   - frame_done at cycle 197; joystick=0; present=2'b11.
   - Next load starts at cycle 206.
2. Pad model with P1=12'h0A5 pressed and P2=12'h801 pressed, data changing after each joy_clk rise.
   - joystick[11:0]=12'h0A5 and joystick[27:16]=12'h801 at frame_done.
   - joystick[15:12]=0 and joystick[31:28]=0.
3. joy_data held 0.
   - present=2'b00, joystick=0.
   - Then P2 pad only connected with button 3 pressed: present=2'b10, joystick[19]=1.
4. Drop enable at cycle 50 of a frame.
   - The frame still commits at its frame_done cycle.
   - After GAP, joy_load stays 1 and joy_clk stays 0 indefinitely.
   - Re-raise enable: joy_load falls on the following cycle.
5. Assert sys_reset=0 for one cycle mid-SHIFT with joystick nonzero.
   - Next cycle: joystick=0, present=0, joy_clk=0, joy_load=1.
   - With enable=1, a fresh frame restarts from LOAD.
6. PLAYERS=4, BITS=16, DIV=8, GAP=1 with a randomised pad model, 20 frames.
   - Each frame_done is 8+1024+1+1 = 1034 cycles apart.
   - Every committed word matches the model.
